// File: rtl/font_pkg.sv
// Shared font constants and glyph bitmap ROM for the text overlay.
// Each glyph body is ten 8-bit rows (rows 2..11); all other rows are blank.
package font_pkg;

    localparam int FONT_W = 8;
    localparam int FONT_H = 16;
    localparam int FONT_N = 16;

    localparam int GLYPH_BLANK = 0;
    localparam int GLYPH_F     = 1;
    localparam int GLYPH_H_CHR = 2;
    localparam int GLYPH_D     = 3;
    localparam int GLYPH_I     = 4;
    localparam int GLYPH_A     = 5;
    localparam int GLYPH_M     = 6;
    localparam int GLYPH_E     = 7;
    localparam int GLYPH_S     = 8;
    localparam int GLYPH_NY    = 9;
    localparam int GLYPH_O     = 10;
    localparam int GLYPH_R     = 11;
    localparam int GLYPH_N     = 12;
    localparam int GLYPH_G     = 13;
    localparam int GLYPH_T     = 14;
    localparam int GLYPH_Z     = 15;

    // Row word for (code, row); body bytes are packed with row 2 in the top byte.
    function automatic logic [FONT_W-1:0] font_row(input int unsigned code, input int unsigned r);
        logic [79:0] body;
        body = '0;
        case (code)
            GLYPH_F:     body = 80'hFE_66_62_68_78_68_60_60_60_F0;
            GLYPH_H_CHR: body = 80'hC6_C6_C6_C6_FE_C6_C6_C6_C6_C6;
            GLYPH_D:     body = 80'hF8_6C_66_66_66_66_66_66_6C_F8;
            GLYPH_I:     body = 80'h3C_18_18_18_18_18_18_18_18_3C;
            GLYPH_A:     body = 80'h10_38_6C_C6_C6_FE_C6_C6_C6_C6;
            GLYPH_M:     body = 80'hC6_EE_FE_FE_D6_C6_C6_C6_C6_C6;
            GLYPH_E:     body = 80'hFE_66_62_68_78_68_60_62_66_FE;
            GLYPH_S:     body = 80'h7C_C6_C6_60_38_0C_06_C6_C6_7C;
            GLYPH_NY:    body = 80'h76_DC_00_C6_E6_F6_DE_CE_C6_C6;
            GLYPH_O:     body = 80'h7C_C6_C6_C6_C6_C6_C6_C6_C6_7C;
            GLYPH_R:     body = 80'hFC_66_66_66_7C_6C_66_66_66_E6;
            GLYPH_N:     body = 80'hC6_E6_F6_FE_DE_CE_C6_C6_C6_C6;
            GLYPH_G:     body = 80'h3C_66_C2_C0_C0_DE_C6_C6_66_3A;
            GLYPH_T:     body = 80'hFF_DB_99_18_18_18_18_18_18_3C;
            GLYPH_Z:     body = 80'hFE_C6_86_0C_18_30_60_C2_C6_FE;
            default:     body = '0;
        endcase
        if (r < 2 || r > 11)
            return '0;
        return body[8*(11-r) +: 8];
    endfunction

endpackage

// File: rtl/font_blink_ctr.sv
// Blink phase generator: counts frame ticks and toggles the phase every
// BLINK_FRAMES ticks.
module font_blink_ctr #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic blink_phase
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_d, cnt_q;
    logic          phase_d, phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/font_pixel_gen.sv
// Two-stage glyph pixel lookup: ROM row read, then column bit select.
// Optional blinking is enabled with the FONT_BLINK_EN macro.
module font_pixel_gen
    import font_pkg::*;
#(
    parameter int GLYPH_W      = FONT_W,
    parameter int GLYPH_H      = FONT_H,
    parameter int N_GLYPHS     = FONT_N,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [$clog2(N_GLYPHS):0]   glyph_id,
    input  logic [$clog2(GLYPH_H)-1:0]  row,
    input  logic [$clog2(GLYPH_W)-1:0]  col,
    input  logic                        blink_req,
    input  logic                        frame_tick,
    output logic                        out_valid,
    output logic [GLYPH_W-1:0]          row_bits,
    output logic                        pixel
);
    localparam int CW = $clog2(GLYPH_W);

    logic               s1_valid_d, s1_valid_q;
    logic [GLYPH_W-1:0] s1_word_d,  s1_word_q;
    logic [CW-1:0]      s1_col_d,   s1_col_q;
    logic               s1_blink_d, s1_blink_q;
    logic               out_valid_d, out_valid_q;
    logic [GLYPH_W-1:0] row_bits_d, row_bits_q;
    logic               pixel_d,    pixel_q;
    logic               in_range;
    logic [CW-1:0]      bit_idx;
    logic               blink_phase;

`ifdef FONT_BLINK_EN
    font_blink_ctr #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );
    assign s1_blink_d = in_valid & blink_req;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_req, frame_tick, s1_blink_q};
    assign blink_phase  = 1'b0;
    assign s1_blink_d   = 1'b0;
`endif

    // Out-of-range codes and rows beyond a non-power-of-two height read as blank.
    assign in_range = (32'(glyph_id) < N_GLYPHS) && (32'(row) < GLYPH_H);
    assign bit_idx  = CW'(GLYPH_W - 1) - s1_col_q;

    always_comb begin
        s1_valid_d  = in_valid;
        s1_word_d   = '0;
        s1_col_d    = '0;
        if (in_valid) begin
            s1_col_d = col;
            if (in_range)
                s1_word_d = GLYPH_W'(font_row(32'(glyph_id), 32'(row)));
        end
        out_valid_d = s1_valid_q;
        row_bits_d  = s1_valid_q ? s1_word_q : '0;
        pixel_d     = s1_word_q[bit_idx] & s1_valid_q & ~(s1_blink_q & blink_phase);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_col_q    <= '0;
            s1_blink_q  <= 1'b0;
            out_valid_q <= 1'b0;
            row_bits_q  <= '0;
            pixel_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_col_q    <= s1_col_d;
            s1_blink_q  <= s1_blink_d;
            out_valid_q <= out_valid_d;
            row_bits_q  <= row_bits_d;
            pixel_q     <= pixel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign row_bits  = row_bits_q;
    assign pixel     = pixel_q;

endmodule

// File: tb/tb_font_pixel_gen.sv
// Directed bench for font_pixel_gen: streamed vector table plus reset-flush
// and (with FONT_BLINK_EN) blink sequences.
module tb_font_pixel_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] glyph_id;
    logic [3:0] row;
    logic [2:0] col;
    logic       blink_req;
    logic       frame_tick;
    logic       out_valid;
    logic [7:0] row_bits;
    logic       pixel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [4:0] g;
        logic [3:0] r;
        logic [2:0] c;
        logic       ev;
        logic [7:0] eb;
        logic       ep;
    } vec_t;

    vec_t vecs[$];

    font_pixel_gen #(.BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .glyph_id   (glyph_id),
        .row        (row),
        .col        (col),
        .blink_req  (blink_req),
        .frame_tick (frame_tick),
        .out_valid  (out_valid),
        .row_bits   (row_bits),
        .pixel      (pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [7:0] eb, input logic ep);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({nm, ".row_bits"},  32'(row_bits),  32'(eb));
        chk({nm, ".pixel"},     32'(pixel),     32'(ep));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] g, input logic [3:0] r, input logic [2:0] c);
        in_valid = v;
        glyph_id = g;
        row      = r;
        col      = c;
    endtask

    function automatic vec_t mk(logic v, logic [4:0] g, logic [3:0] r, logic [2:0] c,
                                logic [7:0] eb, logic ep);
        vec_t t;
        t.v = v; t.g = g; t.r = r; t.c = c;
        t.ev = v; t.eb = eb; t.ep = ep;
        return t;
    endfunction

    initial begin
        // hand-computed expectations: pixel = word[7-col]
        vecs.push_back(mk(1, 1, 2, 0, 8'hFE, 1));
        vecs.push_back(mk(1, 1, 2, 7, 8'hFE, 0));
        for (int r = 2; r <= 11; r++)
            vecs.push_back(mk(1, 2, 4'(r), 3, (r == 6) ? 8'hFE : 8'hC6, (r == 6)));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 13, 0, 8'h00, 0));
        vecs.push_back(mk(1, 16, 2, 0, 8'h00, 0));
        vecs.push_back(mk(1, 31, 2, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 2, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 2, 1, 8'hFE, 1));
        vecs.push_back(mk(0, 2, 6, 3, 8'h00, 0));
        vecs.push_back(mk(1, 3, 2, 4, 8'hF8, 1));
        vecs.push_back(mk(1, 5, 2, 3, 8'h10, 1));
        vecs.push_back(mk(1, 5, 2, 4, 8'h10, 0));
        vecs.push_back(mk(1, 15, 11, 0, 8'hFE, 1));
        vecs.push_back(mk(1, 1, 11, 4, 8'hF0, 0));

        reset = 1'b1; blink_req = 1'b0; frame_tick = 1'b0;
        drive(1, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", 0, 8'h00, 0);
        end
        reset = 1'b0;

        // stream: outputs after edge i belong to the vector driven before edge i-1
        for (int i = 0; i <= vecs.size() + 1; i++) begin
            if (i < vecs.size())
                drive(vecs[i].v, vecs[i].g, vecs[i].r, vecs[i].c);
            else
                drive(0, 0, 0, 0);
            tick();
            if (i >= 1 && i - 1 < vecs.size())
                chk_out($sformatf("vec%0d", i - 1), vecs[i-1].ev, vecs[i-1].eb, vecs[i-1].ep);
        end

        // reset flush with two requests in flight
        drive(1, 1, 2, 0);
        tick();
        reset = 1'b1;
        drive(1, 2, 6, 3);
        tick();
        chk_out("flush.r", 0, 8'h00, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        chk_out("flush.a", 0, 8'h00, 0);
        drive(1, 2, 6, 3);
        tick();
        chk_out("flush.b", 0, 8'h00, 0);
        drive(0, 0, 0, 0);
        tick();
        chk_out("flush.c", 1, 8'hFE, 1);
        tick();
        chk_out("flush.d", 0, 8'h00, 0);

`ifdef FONT_BLINK_EN
        frame_tick = 1'b1;
        tick();
        tick();
        frame_tick = 1'b0;
        blink_req = 1'b1;
        drive(1, 1, 2, 0);
        tick();
        blink_req = 1'b0;
        tick();
        chk_out("blink.on", 1, 8'hFE, 0);
        drive(0, 0, 0, 0);
        tick();
        chk_out("blink.noreq", 1, 8'hFE, 1);
        frame_tick = 1'b1;
        tick();
        tick();
        frame_tick = 1'b0;
        blink_req = 1'b1;
        drive(1, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0);
        blink_req = 1'b0;
        tick();
        chk_out("blink.off", 1, 8'hFE, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
